// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 front end.
package sha256_pkg;

   localparam int unsigned SHA_BLOCK_W  = 512;
   localparam int unsigned SHA_WORD_W   = 32;
   localparam int unsigned SHA_LEN_OFF  = 56;
   localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_EMIT,
      ST_PAD2,
      ST_EMIT2
   } pad_state_e;

endpackage

// File: rtl/sha256_block_padder.sv
// Packs a 32-bit message word stream into SHA-256 padded 512-bit blocks
// and hands them to the hash core over a valid/ready link.
module sha256_block_padder
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_W = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid,
   input  logic [SHA_WORD_W-1:0]  in_data,
   input  logic                   in_last,
   input  logic [2:0]             in_bytes,
   output logic                   in_ready,
   output logic                   blk_valid,
   output logic [SHA_BLOCK_W-1:0] blk_data,
   output logic                   blk_new,
   input  logic                   blk_ready
);

   localparam int unsigned BLK_BYTES = SHA_BLOCK_W / 8;
   localparam int unsigned BLK_WORDS = SHA_BLOCK_W / SHA_WORD_W;

   // Keep bytes below p, place the pad marker at p, clear everything above.
   function automatic logic [SHA_BLOCK_W-1:0] tail_mask(
      input logic [SHA_BLOCK_W-1:0] blk,
      input logic [6:0]             p
   );
      logic [SHA_BLOCK_W-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < BLK_BYTES; b++) begin
         if (b < 32'(p))
            r[SHA_BLOCK_W-1-8*b -: 8] = blk[SHA_BLOCK_W-1-8*b -: 8];
         else if (b == 32'(p))
            r[SHA_BLOCK_W-1-8*b -: 8] = SHA_PAD_BYTE;
      end
      return r;
   endfunction

   function automatic logic [SHA_BLOCK_W-1:0] with_len(
      input logic [SHA_BLOCK_W-1:0] blk,
      input logic [63:0]            bitlen
   );
      logic [SHA_BLOCK_W-1:0] r;
      r = blk;
      r[(BLK_BYTES-SHA_LEN_OFF)*8-1:0] = bitlen;
      return r;
   endfunction

   pad_state_e             state;
   logic [3:0]             wi;
   logic [LEN_W-1:0]       bitcnt;
   logic                   seen;
   logic                   pend;
   logic                   is_final;
   logic                   lead80;

   logic                   accept;
   logic [5:0]             add_bits;
   logic [LEN_W-1:0]       bitcnt_nxt;
   logic [6:0]             tail_pos;
   logic [SHA_BLOCK_W-1:0] merged;
   logic [SHA_BLOCK_W-1:0] tail_blk;
   logic [SHA_BLOCK_W-1:0] pad2_blk;

   always_comb begin
      accept     = in_valid & in_ready;
      add_bits   = in_last ? {in_bytes, 3'b000} : 6'd32;
      bitcnt_nxt = bitcnt + LEN_W'(add_bits);
      tail_pos   = {1'b0, wi, 2'b00} + {4'b0000, in_bytes};
      merged     = blk_data;
      for (int unsigned w = 0; w < BLK_WORDS; w++) begin
         if (4'(w) == wi)
            merged[SHA_BLOCK_W-1-SHA_WORD_W*w -: SHA_WORD_W] = in_data;
      end
      tail_blk   = tail_mask(merged, tail_pos);
      pad2_blk   = '0;
      pad2_blk[SHA_BLOCK_W-1 -: 8] = lead80 ? SHA_PAD_BYTE : 8'h00;
   end

   // The block buffer doubles as the output register; it only changes while
   // blk_valid is low, so it is stable for the core during a stall.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state     <= ST_FILL;
         in_ready  <= 1'b0;
         blk_valid <= 1'b0;
         blk_new   <= 1'b0;
         blk_data  <= '0;
         wi        <= '0;
         bitcnt    <= '0;
         seen      <= 1'b0;
         pend      <= 1'b0;
         is_final  <= 1'b0;
         lead80    <= 1'b0;
      end else begin
         case (state)
            ST_FILL: begin
               in_ready <= 1'b1;
               if (accept) begin
                  bitcnt <= bitcnt_nxt;
                  wi     <= wi + 4'd1;
                  if (!in_last) begin
                     blk_data <= merged;
                     if (wi == 4'd15) begin
                        state     <= ST_EMIT;
                        in_ready  <= 1'b0;
                        blk_valid <= 1'b1;
                        blk_new   <= ~seen;
                        is_final  <= 1'b0;
                        pend      <= 1'b0;
                     end
                  end else begin
                     state     <= ST_EMIT;
                     in_ready  <= 1'b0;
                     blk_valid <= 1'b1;
                     blk_new   <= ~seen;
                     if (tail_pos < 7'(SHA_LEN_OFF)) begin
                        blk_data <= with_len(tail_blk, 64'(bitcnt_nxt));
                        is_final <= 1'b1;
                        pend     <= 1'b0;
                     end else begin
                        // Length does not fit: a second, length-only block follows.
                        blk_data <= tail_blk;
                        is_final <= 1'b0;
                        pend     <= 1'b1;
                        lead80   <= (tail_pos == 7'd64);
                     end
                  end
               end
            end
            ST_EMIT, ST_EMIT2: begin
               if (blk_valid && blk_ready) begin
                  blk_valid <= 1'b0;
                  seen      <= ~is_final;
                  if (is_final)
                     bitcnt <= '0;
                  if (pend) begin
                     state <= ST_PAD2;
                  end else begin
                     state    <= ST_FILL;
                     in_ready <= 1'b1;
                     wi       <= '0;
                  end
               end
            end
            ST_PAD2: begin
               blk_data  <= with_len(pad2_blk, 64'(bitcnt));
               blk_new   <= ~seen;
               blk_valid <= 1'b1;
               is_final  <= 1'b1;
               pend      <= 1'b0;
               state     <= ST_EMIT2;
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Directed bench for sha256_block_padder: table of messages with hand-built
// padded blocks, plus stall and mid-message reset sequences.
module tb_sha256_block_padder;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic         in_ready;
   logic         blk_valid;
   logic [511:0] blk_data;
   logic         blk_new;
   logic         blk_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   sha256_block_padder #(.LEN_W(64)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .in_ready  (in_ready),
      .blk_valid (blk_valid),
      .blk_data  (blk_data),
      .blk_new   (blk_new),
      .blk_ready (blk_ready)
   );

   localparam logic [127:0] P0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] P2 = 128'h202122232425262728292a2b2c2d2e2f;
   localparam logic [127:0] P3 = 128'h303132333435363738393a3b3c3d3e3f;
   localparam logic [511:0] ABC  = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] FIVE = {40'h0001020304, 8'h80, 400'h0, 64'h28};

   typedef struct {
      int           nwords;
      int           lastb;
      logic [31:0]  w0;
      int           nblk;
      logic [511:0] exp0;
      logic [511:0] exp1;
   } vec_t;

   vec_t vecs[8];

   // Word k of a pattern message carries byte values 4k..4k+3.
   function automatic logic [31:0] pat(input int k);
      return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_msg(input int n, input int lastb, input logic [31:0] w0, input bit with_last);
      for (int k = 0; k < n; k++) begin
         int waitc;
         in_valid = 1'b1;
         in_data  = (k == 0) ? w0 : pat(k);
         in_last  = with_last && (k == n - 1);
         in_bytes = in_last ? 3'(lastb) : 3'd6;
         waitc = 0;
         while (!in_ready && waitc < 200) begin
            @(negedge clk_i);
            waitc++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%0d actual=in_ready_low required=accept", k);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(negedge clk_i);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect_one(input string name, input logic [511:0] exp_d, input bit exp_new, input int hold);
      int waitc;
      waitc = 0;
      while (!blk_valid && waitc < 400) begin
         @(negedge clk_i);
         waitc++;
      end
      if (!blk_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_block required=block", name);
         return;
      end
      for (int h = 0; h < hold; h++) begin
         chk({name, "_hold_data"}, blk_data, exp_d);
         chk({name, "_hold_new"}, blk_new, exp_new);
         chk({name, "_hold_in_ready"}, in_ready, 1'b0);
         chk({name, "_hold_valid"}, blk_valid, 1'b1);
         @(negedge clk_i);
      end
      blk_ready = 1'b1;
      chk({name, "_data"}, blk_data, exp_d);
      chk({name, "_new"}, blk_new, exp_new);
      @(negedge clk_i);
      chk({name, "_valid_drop"}, blk_valid, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{nwords: 1,  lastb: 3, w0: 32'h61626300, nblk: 1, exp0: ABC, exp1: '0};
      vecs[1] = '{nwords: 1,  lastb: 0, w0: 32'hdeadbeef, nblk: 1, exp0: {8'h80, 504'h0}, exp1: '0};
      vecs[2] = '{nwords: 2,  lastb: 1, w0: 32'h00010203, nblk: 1, exp0: FIVE, exp1: '0};
      vecs[3] = '{nwords: 14, lastb: 3, w0: 32'h00010203, nblk: 1,
                  exp0: {P0, P1, P2, 56'h30313233343536, 8'h80, 64'h1b8}, exp1: '0};
      vecs[4] = '{nwords: 14, lastb: 4, w0: 32'h00010203, nblk: 2,
                  exp0: {P0, P1, P2, 64'h3031323334353637, 8'h80, 56'h0},
                  exp1: {448'h0, 64'h1c0}};
      vecs[5] = '{nwords: 15, lastb: 4, w0: 32'h00010203, nblk: 2,
                  exp0: {P0, P1, P2, 96'h303132333435363738393a3b, 8'h80, 24'h0},
                  exp1: {448'h0, 64'h1e0}};
      vecs[6] = '{nwords: 16, lastb: 4, w0: 32'h00010203, nblk: 2,
                  exp0: {P0, P1, P2, P3},
                  exp1: {8'h80, 440'h0, 64'h200}};
      vecs[7] = '{nwords: 17, lastb: 1, w0: 32'h00010203, nblk: 2,
                  exp0: {P0, P1, P2, P3},
                  exp1: {8'h40, 8'h80, 432'h0, 64'h208}};

      rst_ni    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_bytes  = '0;
      blk_ready = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_blk_valid", blk_valid, 1'b0);
      chk("rst_blk_new", blk_new, 1'b0);
      chk("rst_blk_data", blk_data, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("release_in_ready", in_ready, 1'b1);

      blk_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         fork
            send_msg(vecs[i].nwords, vecs[i].lastb, vecs[i].w0, 1'b1);
            begin
               collect_one($sformatf("vec%0d_blk0", i), vecs[i].exp0, 1'b1, 0);
               if (vecs[i].nblk > 1)
                  collect_one($sformatf("vec%0d_blk1", i), vecs[i].exp1, 1'b0, 0);
            end
         join
      end

      // Core stalls on the "abc" block while the next message is already waiting.
      blk_ready = 1'b0;
      fork
         begin
            send_msg(1, 3, 32'h61626300, 1'b1);
            send_msg(2, 1, 32'h00010203, 1'b1);
         end
         begin
            collect_one("stall_abc", ABC, 1'b1, 5);
            collect_one("after_stall", FIVE, 1'b1, 0);
         end
      join

      // Reset with seven words already buffered; the partial message must vanish.
      send_msg(7, 0, pat(0), 1'b0);
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_blk_valid", blk_valid, 1'b0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("midrst_release_in_ready", in_ready, 1'b1);
      fork
         send_msg(1, 3, 32'h61626300, 1'b1);
         collect_one("midrst_abc", ABC, 1'b1, 0);
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
